// File: rtl/rx_ml_deskew.sv
// rtl/rx_ml_deskew.sv - multi-lane receive deskew buffer aligned on alignment markers
//
// Purpose:
//   Each enabled lane starts writing into its own circular buffer at its first
//   alignment marker. Once every enabled lane holds at least the threshold,
//   all lanes are popped in lockstep, so words that carried markers on the
//   wire leave the block in the same output cycle. Overflow, underflow, marker
//   misalignment, lane-enable changes and resync requests all go through a
//   single-cycle ERR state that flushes the buffers and re-acquires.
//
// Ports:
//   i_rec_clk          sole clock
//   r_r_unif_rst_n     asynchronous active-low reset
//   i_r_wr_data        per-lane write words, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_r_wr_data_valid  per-lane write strobe
//   i_r_wr_data_isam   per-lane alignment-marker flag
//   i_r_lane_en        per-lane participation enable
//   i_r_half_thres     occupancy needed on every enabled lane to start reading
//   i_r_rd_en          downstream read cadence
//   i_r_resync         flush and re-acquire request
//   o_r_rd_data        deskewed words (latency 1 from the pop)
//   o_r_rd_data_isam   marker flag of each output word
//   o_r_rd_data_valid  common output valid
//   o_r_state          IDLE=0, FILL=1, RUN=2, ERR=3
//   o_r_aligned        state is RUN
//   o_r_overflow       per-lane overflow pulse
//   o_r_underflow      per-lane underflow pulse
//   o_r_am_mismatch    marker misalignment pulse
//   o_r_occ            per-lane occupancy, (ADD_WIDTH+1) bits per lane
//   o_r_flow_cnt       saturating count of error-driven ERR entries

module rx_ml_deskew #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 9,
  parameter int ADD_WIDTH  = 4
) (
  input  logic                           i_rec_clk,
  input  logic                           r_r_unif_rst_n,
  input  logic [LANES*DATA_WIDTH-1:0]    i_r_wr_data,
  input  logic [LANES-1:0]               i_r_wr_data_valid,
  input  logic [LANES-1:0]               i_r_wr_data_isam,
  input  logic [LANES-1:0]               i_r_lane_en,
  input  logic [ADD_WIDTH-1:0]           i_r_half_thres,
  input  logic                           i_r_rd_en,
  input  logic                           i_r_resync,
  output logic [LANES*DATA_WIDTH-1:0]    o_r_rd_data,
  output logic [LANES-1:0]               o_r_rd_data_isam,
  output logic                           o_r_rd_data_valid,
  output logic [1:0]                     o_r_state,
  output logic                           o_r_aligned,
  output logic [LANES-1:0]               o_r_overflow,
  output logic [LANES-1:0]               o_r_underflow,
  output logic                           o_r_am_mismatch,
  output logic [LANES*(ADD_WIDTH+1)-1:0] o_r_occ,
  output logic [7:0]                     o_r_flow_cnt
);

  localparam int DEPTH = 1 << ADD_WIDTH;
  localparam int PW    = ADD_WIDTH + 1;
  localparam int WW    = DATA_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   cnt_inc;

  logic                             in_err;
  logic                             pop_req;
  logic [LANES-1:0]                 rd_lane;
  logic [LANES-1:0]                 wr_lane;
  logic [LANES-1:0]                 ovf;
  logic [LANES-1:0]                 udf;
  logic [LANES-1:0]                 ready;
  logic [LANES-1:0]                 head_isam;
  logic [LANES-1:0][DATA_WIDTH-1:0] head_data;
  logic [LANES-1:0]                 lane_en_q;
  logic                             mismatch;
  logic                             err_flow;
  logic                             en_change;

  assign in_err  = (state_q == ST_ERR);
  assign pop_req = (state_q == ST_RUN) & i_r_rd_en;

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      logic [PW-1:0] wr_ptr;
      logic [PW-1:0] rd_ptr;
      logic [PW-1:0] occ;
      logic [WW-1:0] mem [DEPTH];
      logic          got_am;
      logic          wr_try;
      logic [WW-1:0] head;

      assign occ = wr_ptr - rd_ptr;

      // An underflowing lane is not popped so its pointers stay consistent;
      // the buffers are flushed on the way through ERR anyway.
      assign rd_lane[g] = pop_req & i_r_lane_en[g] & (occ != '0);
      assign udf[g]     = pop_req & i_r_lane_en[g] & (occ == '0);

      assign wr_try = i_r_lane_en[g] & i_r_wr_data_valid[g]
                    & (got_am | i_r_wr_data_isam[g]) & ~in_err;

      // Occupancy never exceeds DEPTH, so its MSB alone marks a full buffer.
      assign ovf[g]     = wr_try & occ[ADD_WIDTH] & ~rd_lane[g];
      assign wr_lane[g] = wr_try & ~ovf[g];

      assign ready[g] = ~i_r_lane_en[g] | (occ >= {1'b0, i_r_half_thres});

      assign head         = mem[rd_ptr[ADD_WIDTH-1:0]];
      assign head_isam[g] = head[DATA_WIDTH];
      assign head_data[g] = head[DATA_WIDTH-1:0];

      assign o_r_occ[g*PW +: PW] = occ;

      always_ff @(posedge i_rec_clk or negedge r_r_unif_rst_n) begin
        if (!r_r_unif_rst_n) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          got_am <= 1'b0;
        end else if (in_err) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          got_am <= 1'b0;
        end else begin
          if (!i_r_lane_en[g]) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
          end else begin
            if (wr_lane[g]) wr_ptr <= wr_ptr + PW'(1);
            if (rd_lane[g]) rd_ptr <= rd_ptr + PW'(1);
          end
          // Only a participating lane may arm itself; otherwise a later
          // enable from IDLE would start writing mid-stream.
          if (i_r_lane_en[g] & i_r_wr_data_valid[g] & i_r_wr_data_isam[g])
            got_am <= 1'b1;
        end
      end

      always_ff @(posedge i_rec_clk) begin
        if (wr_lane[g])
          mem[wr_ptr[ADD_WIDTH-1:0]] <= {i_r_wr_data_isam[g],
                                         i_r_wr_data[g*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
  endgenerate

  // Misalignment: among the lanes actually popped, some carry a marker and
  // some do not.
  assign mismatch  = (|(rd_lane & head_isam)) & (|(rd_lane & ~head_isam));
  assign err_flow  = (|ovf) | (|udf) | mismatch;
  assign en_change = ((state_q == ST_FILL) | (state_q == ST_RUN))
                   & (i_r_lane_en != lane_en_q);

  always_ff @(posedge i_rec_clk or negedge r_r_unif_rst_n) begin
    if (!r_r_unif_rst_n) state_q <= ST_IDLE;
    else                 state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_inc = 1'b0;
    case (state_q)
      ST_IDLE: if (|i_r_lane_en) state_d = ST_FILL;
      ST_FILL: if (&ready)       state_d = ST_RUN;
      ST_RUN:                    state_d = ST_RUN;
      default:                   state_d = ST_IDLE;
    endcase
    // Resync wins over any simultaneous error and is never counted.
    if (i_r_resync) begin
      state_d = ST_ERR;
    end else if (err_flow | en_change) begin
      state_d = ST_ERR;
      cnt_inc = err_flow;
    end
  end

  always_ff @(posedge i_rec_clk or negedge r_r_unif_rst_n) begin
    if (!r_r_unif_rst_n) begin
      o_r_rd_data       <= '0;
      o_r_rd_data_isam  <= '0;
      o_r_rd_data_valid <= 1'b0;
      o_r_overflow      <= '0;
      o_r_underflow     <= '0;
      o_r_am_mismatch   <= 1'b0;
      o_r_flow_cnt      <= '0;
      lane_en_q         <= '0;
    end else begin
      o_r_rd_data_valid <= pop_req & ~(|udf);
      if (pop_req) begin
        for (int k = 0; k < LANES; k++) begin
          o_r_rd_data[k*DATA_WIDTH +: DATA_WIDTH] <= rd_lane[k] ? head_data[k] : '0;
          o_r_rd_data_isam[k]                     <= rd_lane[k] & head_isam[k];
        end
      end
      o_r_overflow    <= ovf;
      o_r_underflow   <= udf;
      o_r_am_mismatch <= mismatch;
      lane_en_q       <= i_r_lane_en;
      if (cnt_inc && (o_r_flow_cnt != 8'hFF))
        o_r_flow_cnt <= o_r_flow_cnt + 8'd1;
    end
  end

  assign o_r_state   = state_q;
  assign o_r_aligned = (state_q == ST_RUN);

endmodule

// File: tb/tb_rx_ml_deskew.sv
// tb/tb_rx_ml_deskew.sv - directed self-checking bench for rx_ml_deskew

module tb_rx_ml_deskew;
  localparam int LANES = 4;
  localparam int DW    = 9;
  localparam int AW    = 4;
  localparam int PW    = AW + 1;

  logic                    i_rec_clk = 1'b0;
  logic                    r_r_unif_rst_n;
  logic [LANES*DW-1:0]     i_r_wr_data;
  logic [LANES-1:0]        i_r_wr_data_valid;
  logic [LANES-1:0]        i_r_wr_data_isam;
  logic [LANES-1:0]        i_r_lane_en;
  logic [AW-1:0]           i_r_half_thres;
  logic                    i_r_rd_en;
  logic                    i_r_resync;
  logic [LANES*DW-1:0]     o_r_rd_data;
  logic [LANES-1:0]        o_r_rd_data_isam;
  logic                    o_r_rd_data_valid;
  logic [1:0]              o_r_state;
  logic                    o_r_aligned;
  logic [LANES-1:0]        o_r_overflow;
  logic [LANES-1:0]        o_r_underflow;
  logic                    o_r_am_mismatch;
  logic [LANES*PW-1:0]     o_r_occ;
  logic [7:0]              o_r_flow_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int lane_start [LANES];
  int lane_stop  [LANES];
  int shift_lane;

  always #5 i_rec_clk = ~i_rec_clk;

  rx_ml_deskew #(.LANES(LANES), .DATA_WIDTH(DW), .ADD_WIDTH(AW)) dut (
    .i_rec_clk         (i_rec_clk),
    .r_r_unif_rst_n    (r_r_unif_rst_n),
    .i_r_wr_data       (i_r_wr_data),
    .i_r_wr_data_valid (i_r_wr_data_valid),
    .i_r_wr_data_isam  (i_r_wr_data_isam),
    .i_r_lane_en       (i_r_lane_en),
    .i_r_half_thres    (i_r_half_thres),
    .i_r_rd_en         (i_r_rd_en),
    .i_r_resync        (i_r_resync),
    .o_r_rd_data       (o_r_rd_data),
    .o_r_rd_data_isam  (o_r_rd_data_isam),
    .o_r_rd_data_valid (o_r_rd_data_valid),
    .o_r_state         (o_r_state),
    .o_r_aligned       (o_r_aligned),
    .o_r_overflow      (o_r_overflow),
    .o_r_underflow     (o_r_underflow),
    .o_r_am_mismatch   (o_r_am_mismatch),
    .o_r_occ           (o_r_occ),
    .o_r_flow_cnt      (o_r_flow_cnt)
  );

  // Lane k word number seq (counted from its first marker) carries k*64+seq;
  // markers every 16 words, except the shifted lane after its first marker.
  task automatic drive(input int c);
    int seq;
    for (int k = 0; k < LANES; k++) begin
      i_r_wr_data_valid[k] = (c < lane_stop[k]);
      if (c >= lane_start[k]) begin
        seq = c - lane_start[k];
        i_r_wr_data[k*DW +: DW] = DW'(k*64 + seq%64);
        if (k == shift_lane && seq >= 16) i_r_wr_data_isam[k] = (seq%16 == 1);
        else                              i_r_wr_data_isam[k] = (seq%16 == 0);
      end else begin
        i_r_wr_data[k*DW +: DW] = '0;
        i_r_wr_data_isam[k]     = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge i_rec_clk);
    #1;
  endtask

  task automatic do_reset();
    r_r_unif_rst_n    = 1'b0;
    i_r_wr_data       = '0;
    i_r_wr_data_valid = '0;
    i_r_wr_data_isam  = '0;
    i_r_lane_en       = '0;
    i_r_half_thres    = '0;
    i_r_rd_en         = 1'b0;
    i_r_resync        = 1'b0;
    shift_lane        = -1;
    for (int k = 0; k < LANES; k++) begin
      lane_start[k] = 0;
      lane_stop[k]  = 1000000;
    end
    repeat (2) @(posedge i_rec_clk);
    #1;
    r_r_unif_rst_n = 1'b1;
  endtask

  function automatic logic [LANES*DW-1:0] exp_word(input int j, input logic [LANES-1:0] m);
    logic [LANES*DW-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++)
      if (m[k]) r[k*DW +: DW] = DW'(k*64 + j);
    return r;
  endfunction

  task automatic test_reset();
    do_reset();
    n_checks++; if (o_r_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", o_r_state); end
    n_checks++; if (o_r_rd_data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", o_r_rd_data_valid); end
    n_checks++; if (o_r_rd_data !== '0) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", o_r_rd_data); end
    n_checks++; if (o_r_occ !== '0) begin n_fail++; $display("FAIL reset_occ: got %0h expected 0", o_r_occ); end
    n_checks++; if (o_r_flow_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_flow: got %0d expected 0", o_r_flow_cnt); end
    n_checks++; if (o_r_aligned !== 1'b0) begin n_fail++; $display("FAIL reset_aligned: got %0b expected 0", o_r_aligned); end
  endtask

  task automatic test_deskew();
    int j;
    logic [LANES-1:0] ei;
    do_reset();
    i_r_lane_en = 4'hF; i_r_half_thres = 4'd6; i_r_rd_en = 1'b1;
    lane_start = '{0, 2, 3, 5};
    for (int c = 0; c <= 40; c++) begin
      drive(c);
      step();
      if (c == 10) begin
        n_checks++; if (o_r_occ[3*PW +: PW] !== 5'd6) begin n_fail++; $display("FAIL deskew_occ3: got %0d expected 6", o_r_occ[3*PW +: PW]); end
        n_checks++; if (o_r_occ[0 +: PW] !== 5'd11) begin n_fail++; $display("FAIL deskew_occ0: got %0d expected 11", o_r_occ[0 +: PW]); end
        n_checks++; if (o_r_state !== 2'd1) begin n_fail++; $display("FAIL deskew_fill: got %0d expected 1", o_r_state); end
      end
      if (c == 11) begin
        n_checks++; if (o_r_state !== 2'd2 || o_r_aligned !== 1'b1) begin n_fail++; $display("FAIL deskew_run: got state %0d aligned %0b expected 2/1", o_r_state, o_r_aligned); end
        n_checks++; if (o_r_rd_data_valid !== 1'b0) begin n_fail++; $display("FAIL deskew_novalid: got %0b expected 0", o_r_rd_data_valid); end
      end
      if (c >= 12) begin
        j  = c - 12;
        ei = (j%16 == 0) ? 4'hF : 4'h0;
        n_checks++; if (o_r_rd_data_valid !== 1'b1) begin n_fail++; $display("FAIL deskew_valid j=%0d: got %0b expected 1", j, o_r_rd_data_valid); end
        n_checks++; if (o_r_rd_data !== exp_word(j, 4'hF)) begin n_fail++; $display("FAIL deskew_data j=%0d: got %0h expected %0h", j, o_r_rd_data, exp_word(j, 4'hF)); end
        n_checks++; if (o_r_rd_data_isam !== ei) begin n_fail++; $display("FAIL deskew_isam j=%0d: got %0b expected %0b", j, o_r_rd_data_isam, ei); end
        n_checks++; if (o_r_am_mismatch !== 1'b0) begin n_fail++; $display("FAIL deskew_mm j=%0d: got %0b expected 0", j, o_r_am_mismatch); end
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    i_r_lane_en = 4'b0011; i_r_half_thres = 4'd15; i_r_rd_en = 1'b0;
    lane_start = '{0, 17, 0, 0};
    for (int c = 0; c <= 18; c++) begin
      drive(c);
      step();
      if (c == 15) begin
        n_checks++; if (o_r_occ[0 +: PW] !== 5'd16) begin n_fail++; $display("FAIL ovf_full_occ: got %0d expected 16", o_r_occ[0 +: PW]); end
        n_checks++; if (o_r_state !== 2'd1 || o_r_overflow !== 4'b0000) begin n_fail++; $display("FAIL ovf_pre: got state %0d ovf %0b expected 1/0000", o_r_state, o_r_overflow); end
      end
      if (c == 16) begin
        n_checks++; if (o_r_overflow !== 4'b0001) begin n_fail++; $display("FAIL ovf_pulse: got %0b expected 0001", o_r_overflow); end
        n_checks++; if (o_r_state !== 2'd3) begin n_fail++; $display("FAIL ovf_err: got %0d expected 3", o_r_state); end
        n_checks++; if (o_r_flow_cnt !== 8'd1) begin n_fail++; $display("FAIL ovf_flow: got %0d expected 1", o_r_flow_cnt); end
      end
      if (c == 17) begin
        n_checks++; if (o_r_state !== 2'd0 || o_r_overflow !== 4'b0000) begin n_fail++; $display("FAIL ovf_idle: got state %0d ovf %0b expected 0/0000", o_r_state, o_r_overflow); end
        n_checks++; if (o_r_occ[0 +: PW] !== 5'd0 || o_r_flow_cnt !== 8'd1) begin n_fail++; $display("FAIL ovf_flush: got occ0 %0d flow %0d expected 0/1", o_r_occ[0 +: PW], o_r_flow_cnt); end
      end
    end
  endtask

  task automatic test_underflow();
    do_reset();
    i_r_lane_en = 4'hF; i_r_half_thres = 4'd4; i_r_rd_en = 1'b1;
    lane_stop[2] = 10;
    for (int c = 0; c <= 16; c++) begin
      drive(c);
      step();
      if (c == 4) begin
        n_checks++; if (o_r_state !== 2'd2) begin n_fail++; $display("FAIL udf_run: got %0d expected 2", o_r_state); end
      end
      if (c == 5) begin
        n_checks++; if (o_r_rd_data_valid !== 1'b1 || o_r_rd_data !== exp_word(0, 4'hF) || o_r_rd_data_isam !== 4'hF) begin n_fail++; $display("FAIL udf_first: got v %0b d %0h i %0b expected 1/%0h/1111", o_r_rd_data_valid, o_r_rd_data, o_r_rd_data_isam, exp_word(0, 4'hF)); end
      end
      if (c == 14) begin
        n_checks++; if (o_r_occ[2*PW +: PW] !== 5'd0) begin n_fail++; $display("FAIL udf_occ2: got %0d expected 0", o_r_occ[2*PW +: PW]); end
        n_checks++; if (o_r_rd_data_valid !== 1'b1 || o_r_rd_data !== exp_word(9, 4'hF)) begin n_fail++; $display("FAIL udf_last: got v %0b d %0h expected 1/%0h", o_r_rd_data_valid, o_r_rd_data, exp_word(9, 4'hF)); end
        n_checks++; if (o_r_underflow !== 4'b0000 || o_r_state !== 2'd2) begin n_fail++; $display("FAIL udf_pre: got udf %0b state %0d expected 0000/2", o_r_underflow, o_r_state); end
      end
      if (c == 15) begin
        n_checks++; if (o_r_underflow !== 4'b0100) begin n_fail++; $display("FAIL udf_pulse: got %0b expected 0100", o_r_underflow); end
        n_checks++; if (o_r_rd_data_valid !== 1'b0) begin n_fail++; $display("FAIL udf_suppress: got %0b expected 0", o_r_rd_data_valid); end
        n_checks++; if (o_r_state !== 2'd3 || o_r_flow_cnt !== 8'd1) begin n_fail++; $display("FAIL udf_err: got state %0d flow %0d expected 3/1", o_r_state, o_r_flow_cnt); end
      end
      if (c == 16) begin
        n_checks++; if (o_r_state !== 2'd0 || o_r_underflow !== 4'b0000) begin n_fail++; $display("FAIL udf_idle: got state %0d udf %0b expected 0/0000", o_r_state, o_r_underflow); end
      end
    end
  endtask

  task automatic test_mismatch();
    do_reset();
    i_r_lane_en = 4'hF; i_r_half_thres = 4'd4; i_r_rd_en = 1'b1;
    shift_lane = 1;
    for (int c = 0; c <= 22; c++) begin
      drive(c);
      step();
      if (c == 20) begin
        n_checks++; if (o_r_state !== 2'd2 || o_r_am_mismatch !== 1'b0) begin n_fail++; $display("FAIL mm_pre: got state %0d mm %0b expected 2/0", o_r_state, o_r_am_mismatch); end
        n_checks++; if (o_r_rd_data !== exp_word(15, 4'hF)) begin n_fail++; $display("FAIL mm_data15: got %0h expected %0h", o_r_rd_data, exp_word(15, 4'hF)); end
      end
      if (c == 21) begin
        n_checks++; if (o_r_am_mismatch !== 1'b1) begin n_fail++; $display("FAIL mm_pulse: got %0b expected 1", o_r_am_mismatch); end
        n_checks++; if (o_r_state !== 2'd3 || o_r_flow_cnt !== 8'd1) begin n_fail++; $display("FAIL mm_err: got state %0d flow %0d expected 3/1", o_r_state, o_r_flow_cnt); end
        n_checks++; if (o_r_rd_data_isam !== 4'b1101) begin n_fail++; $display("FAIL mm_isam: got %0b expected 1101", o_r_rd_data_isam); end
      end
      if (c == 22) begin
        n_checks++; if (o_r_state !== 2'd0 || o_r_am_mismatch !== 1'b0) begin n_fail++; $display("FAIL mm_idle: got state %0d mm %0b expected 0/0", o_r_state, o_r_am_mismatch); end
      end
    end
  endtask

  task automatic test_lane_disable();
    do_reset();
    i_r_lane_en = 4'hF; i_r_half_thres = 4'd4; i_r_rd_en = 1'b1;
    for (int c = 0; c <= 21; c++) begin
      if (c == 10) i_r_lane_en = 4'b0111;
      drive(c);
      step();
      if (c == 9) begin
        n_checks++; if (o_r_state !== 2'd2) begin n_fail++; $display("FAIL dis_run: got %0d expected 2", o_r_state); end
      end
      if (c == 10) begin
        n_checks++; if (o_r_state !== 2'd3 || o_r_flow_cnt !== 8'd0) begin n_fail++; $display("FAIL dis_err: got state %0d flow %0d expected 3/0", o_r_state, o_r_flow_cnt); end
      end
      if (c == 11) begin
        n_checks++; if (o_r_state !== 2'd0) begin n_fail++; $display("FAIL dis_idle: got %0d expected 0", o_r_state); end
      end
      if (c == 12) begin
        n_checks++; if (o_r_state !== 2'd1) begin n_fail++; $display("FAIL dis_fill: got %0d expected 1", o_r_state); end
      end
      if (c == 19) begin
        n_checks++; if (o_r_occ[0 +: PW] !== 5'd4 || o_r_occ[3*PW +: PW] !== 5'd0) begin n_fail++; $display("FAIL dis_occ: got occ0 %0d occ3 %0d expected 4/0", o_r_occ[0 +: PW], o_r_occ[3*PW +: PW]); end
      end
      if (c == 20) begin
        n_checks++; if (o_r_state !== 2'd2) begin n_fail++; $display("FAIL dis_rerun: got %0d expected 2", o_r_state); end
      end
      if (c == 21) begin
        n_checks++; if (o_r_rd_data_valid !== 1'b1 || o_r_rd_data !== exp_word(16, 4'b0111)) begin n_fail++; $display("FAIL dis_data: got v %0b d %0h expected 1/%0h", o_r_rd_data_valid, o_r_rd_data, exp_word(16, 4'b0111)); end
        n_checks++; if (o_r_rd_data_isam !== 4'b0111 || o_r_flow_cnt !== 8'd0) begin n_fail++; $display("FAIL dis_isam: got i %0b flow %0d expected 0111/0", o_r_rd_data_isam, o_r_flow_cnt); end
      end
    end
  endtask

  task automatic test_resync();
    do_reset();
    i_r_lane_en = 4'hF; i_r_half_thres = 4'd4; i_r_rd_en = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      i_r_resync = (c == 8);
      drive(c);
      step();
      if (c == 7) begin
        n_checks++; if (o_r_state !== 2'd2 || o_r_rd_data_valid !== 1'b1) begin n_fail++; $display("FAIL rs_run: got state %0d v %0b expected 2/1", o_r_state, o_r_rd_data_valid); end
      end
      if (c == 8) begin
        n_checks++; if (o_r_state !== 2'd3 || o_r_flow_cnt !== 8'd0) begin n_fail++; $display("FAIL rs_err: got state %0d flow %0d expected 3/0", o_r_state, o_r_flow_cnt); end
      end
      if (c == 9) begin
        n_checks++; if (o_r_state !== 2'd0 || o_r_occ !== '0) begin n_fail++; $display("FAIL rs_idle: got state %0d occ %0h expected 0/0", o_r_state, o_r_occ); end
      end
    end
    i_r_resync = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    i_r_lane_en = 4'b0001; i_r_half_thres = 4'd0; i_r_rd_en = 1'b1;
    for (int k = 0; k < LANES; k++) lane_stop[k] = 0;
    for (int c = 0; c <= 1100; c++) begin
      drive(c);
      step();
      if (c == 2) begin
        n_checks++; if (o_r_underflow !== 4'b0001 || o_r_flow_cnt !== 8'd1) begin n_fail++; $display("FAIL sat_first: got udf %0b flow %0d expected 0001/1", o_r_underflow, o_r_flow_cnt); end
      end
      if (c == 1016) begin
        n_checks++; if (o_r_flow_cnt !== 8'd254) begin n_fail++; $display("FAIL sat_254: got %0d expected 254", o_r_flow_cnt); end
      end
      if (c == 1018) begin
        n_checks++; if (o_r_flow_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_255: got %0d expected 255", o_r_flow_cnt); end
      end
      if (c == 1100) begin
        n_checks++; if (o_r_flow_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d expected 255", o_r_flow_cnt); end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    i_r_lane_en = 4'hF; i_r_half_thres = 4'd4; i_r_rd_en = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      drive(c);
      step();
    end
    n_checks++; if (o_r_aligned !== 1'b1 || o_r_rd_data_valid !== 1'b1) begin n_fail++; $display("FAIL mid_run: got aligned %0b v %0b expected 1/1", o_r_aligned, o_r_rd_data_valid); end
    r_r_unif_rst_n = 1'b0;
    #1;
    n_checks++; if (o_r_state !== 2'd0 || o_r_aligned !== 1'b0) begin n_fail++; $display("FAIL mid_rst_state: got state %0d aligned %0b expected 0/0", o_r_state, o_r_aligned); end
    n_checks++; if (o_r_rd_data !== '0 || o_r_rd_data_isam !== '0 || o_r_rd_data_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out: got d %0h i %0b v %0b expected 0", o_r_rd_data, o_r_rd_data_isam, o_r_rd_data_valid); end
    n_checks++; if (o_r_occ !== '0 || o_r_flow_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_rst_occ: got occ %0h flow %0d expected 0/0", o_r_occ, o_r_flow_cnt); end
    @(posedge i_rec_clk);
    #1;
    r_r_unif_rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_deskew();
    test_overflow();
    test_underflow();
    test_mismatch();
    test_lane_disable();
    test_resync();
    test_saturate();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
